// File: rtl/debug_tx_framer_if.sv
// Handshake bundle between the debug decoder/UART TX (master) and the framer (slave).
interface debug_tx_framer_if;
    logic        start;
    logic [31:0] result;
    logic [1:0]  size;
    logic        busy;
    logic        done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;

    modport master (
        output start, result, size, tx_done,
        input  busy, done, tx_start, tx_data
    );

    modport slave (
        input  start, result, size, tx_done,
        output busy, done, tx_start, tx_data
    );
endinterface

// File: rtl/debug_tx_framer.sv
// Serialises a latched debug word (size+1 bytes, LSB first, optional header)
// into the byte-wide UART TX using a start/done handshake.
module debug_tx_framer #(
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input logic               clk,
    input logic               reset,
    debug_tx_framer_if.slave  bus
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  cnt;
        logic        hdr;
    } frame_t;

    state_t state;
    frame_t frm;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            frm          <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        frm.word     <= bus.result;
                        frm.cnt      <= bus.size;
                        bus.busy     <= 1'b1;
                        bus.tx_start <= 1'b1;
                        state        <= S_WAIT;
                        if (HEADER_EN) begin
                            bus.tx_data <= HEADER_BYTE;
                            frm.hdr     <= 1'b1;
                        end else begin
                            bus.tx_data <= bus.result[7:0];
                            frm.hdr     <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    // A tx_done coinciding with our own tx_start cannot belong to this byte.
                    if (bus.tx_done && !bus.tx_start) begin
                        if (frm.hdr) begin
                            frm.hdr      <= 1'b0;
                            bus.tx_data  <= frm.word[7:0];
                            bus.tx_start <= 1'b1;
                        end else if (frm.cnt != 2'd0) begin
                            frm.word     <= {8'h00, frm.word[31:8]};
                            frm.cnt      <= frm.cnt - 2'd1;
                            bus.tx_data  <= frm.word[15:8];
                            bus.tx_start <= 1'b1;
                        end else begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_tx_framer.sv
// Directed bench: one framer with header, one without, driven through a shared stimulus mux.
module tb_debug_tx_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;      // 0: header DUT, 1: no-header DUT
    logic        st = 1'b0;
    logic        td = 1'b0;
    logic [31:0] res = '0;
    logic [1:0]  sz = '0;
    int          tests = 0;
    int          fails = 0;
    int          nts_h = 0;
    int          nts_n = 0;
    int          base;

    debug_tx_framer_if bh();
    debug_tx_framer_if bn();

    assign bh.start   = st & ~sel;
    assign bn.start   = st & sel;
    assign bh.tx_done = td & ~sel;
    assign bn.tx_done = td & sel;
    assign bh.result  = res;
    assign bn.result  = res;
    assign bh.size    = sz;
    assign bn.size    = sz;

    logic       ts_s, busy_s, done_s;
    logic [7:0] data_s;
    assign ts_s   = sel ? bn.tx_start : bh.tx_start;
    assign busy_s = sel ? bn.busy     : bh.busy;
    assign done_s = sel ? bn.done     : bh.done;
    assign data_s = sel ? bn.tx_data  : bh.tx_data;

    debug_tx_framer #(.HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)) dut_h (
        .clk(clk), .reset(reset), .bus(bh.slave));
    debug_tx_framer #(.HEADER_EN(1'b0), .HEADER_BYTE(8'hA5)) dut_n (
        .clk(clk), .reset(reset), .bus(bn.slave));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bh.tx_start) nts_h <= nts_h + 1;
        if (bn.tx_start) nts_n <= nts_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serves n bytes: expects tx_start now, answers tx_done 10 cycles later.
    // Returns at the negedge where done should be visible.
    task automatic frame(input int n, input logic [39:0] exp, input bit inj);
        for (int i = 0; i < n; i++) begin
            chk("tx_start", ts_s, 1);
            chk("tx_data", data_s, exp[8*i +: 8]);
            chk("busy", busy_s, 1);
            @(negedge clk);
            chk("tx_start_pulse", ts_s, 0);
            for (int k = 0; k < 8; k++) begin
                if (inj && i == 0 && k == 2) begin
                    st  = 1'b1;
                    res = 32'h11111111;
                    sz  = 2'd3;
                end else begin
                    st = 1'b0;
                end
                @(negedge clk);
            end
            st = 1'b0;
            chk("tx_data_hold", data_s, exp[8*i +: 8]);
            chk("no_early_done", done_s, 0);
            td = 1'b1;
            @(negedge clk);
            td = 1'b0;
        end
        chk("done", done_s, 1);
        chk("busy_at_done", busy_s, 0);
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tx_start", bh.tx_start, 0);
        chk("rst_tx_data", bh.tx_data, 8'h00);
        chk("rst_busy", bh.busy, 0);
        chk("rst_done", bh.done, 0);
        chk("rst_n_busy", bn.busy, 0);
        chk("rst_n_data", bn.tx_data, 8'h00);
        repeat (20) @(negedge clk);
        chk("idle_no_tx_start_h", nts_h, 0);
        chk("idle_no_tx_start_n", nts_n, 0);

        // Full 4-byte frame with header
        sel = 1'b0; res = 32'h12345678; sz = 2'd3; st = 1'b1;
        base = nts_h;
        @(negedge clk);
        st = 1'b0;
        frame(5, 40'h12345678A5, 1'b0);
        chk("count_full", nts_h - base, 5);
        @(negedge clk);
        chk("done_one_cycle", done_s, 0);

        // Single byte, no header
        sel = 1'b1; res = 32'h000000FF; sz = 2'd0; st = 1'b1;
        base = nts_n;
        @(negedge clk);
        st = 1'b0;
        frame(1, 40'h00000000FF, 1'b0);
        chk("count_single", nts_n - base, 1);
        @(negedge clk);

        // Busy protection: second start mid-frame is ignored
        res = 32'hAABBCCDD; sz = 2'd1; st = 1'b1;
        base = nts_n;
        @(negedge clk);
        st = 1'b0; res = 32'h0; sz = 2'd0;
        frame(2, 40'h000000CCDD, 1'b1);
        @(negedge clk);
        chk("count_busy_prot", nts_n - base, 2);
        chk("idle_after_prot", busy_s, 0);

        // Back-to-back: start in the done cycle
        sel = 1'b0; res = 32'h00000042; sz = 2'd0; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        frame(2, 40'h00000042A5, 1'b0);
        res = 32'h0000BEEF; sz = 2'd1; st = 1'b1;
        base = nts_h;
        @(negedge clk);
        st = 1'b0;
        chk("b2b_done_gone", done_s, 0);
        frame(3, 40'h0000BEEFA5, 1'b0);
        chk("count_b2b", nts_h - base, 3);
        @(negedge clk);

        // Reset after the 2nd byte's tx_start
        res = 32'h12345678; sz = 2'd3; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        chk("mid_hdr", data_s, 8'hA5);
        repeat (9) @(negedge clk);
        td = 1'b1;
        @(negedge clk);
        td = 1'b0;
        chk("mid_byte2_start", ts_s, 1);
        chk("mid_byte2_data", data_s, 8'h78);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        base = nts_h;
        chk("mid_rst_tx_start", ts_s, 0);
        chk("mid_rst_busy", busy_s, 0);
        chk("mid_rst_data", data_s, 8'h00);
        repeat (3) @(negedge clk);
        td = 1'b1;
        @(negedge clk);
        td = 1'b0;
        repeat (5) @(negedge clk);
        chk("late_done_ignored", nts_h - base, 0);
        chk("late_done_busy", busy_s, 0);
        chk("late_done_done", done_s, 0);

        // Fresh frame after the abort
        res = 32'hCAFEF00D; sz = 2'd2; st = 1'b1;
        base = nts_h;
        @(negedge clk);
        st = 1'b0;
        frame(4, 40'h00FEF00DA5, 1'b0);
        chk("count_fresh", nts_h - base, 4);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debug_tx_framer.md
Name: debug_tx_framer

Overview:
- Downstream consumer of the debug decoder output.
- Captures the 32-bit debug `result` and 2-bit `size` on a `start` strobe.
- Serialises (size+1) bytes, optionally preceded by a header byte, to the byte-wide UART transmitter using a start/done handshake.
- Sits between the debug decoder and the UART TX that returns debug data to the host PC.

Parameters:
- HEADER_EN, 1, 1 = send HEADER_BYTE before the data bytes; 0 = data bytes only.
- HEADER_BYTE, 8'hA5, value of the frame header byte.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to send a frame; sampled only in IDLE.
- result  input  32  debug word from the decoder; latched when start is accepted.
- size  input  2  byte count minus one (0→1 byte … 3→4 bytes); latched with result.
- tx_done  input  1  one-cycle pulse from UART TX: current byte fully shifted out.
- tx_start  output  1  one-cycle pulse: UART TX loads tx_data.
- tx_data  output  8  byte to transmit; held stable from tx_start until the matching tx_done.
- busy  output  1  high from start acceptance until frame completion.
- done  output  1  one-cycle pulse after the last byte's tx_done.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clock edge) forces:
  - state=IDLE;
  - tx_start=0, tx_data=8'h00, busy=0, done=0;
  - the latched word, byte counter and header flag are cleared.
- Reset mid-frame aborts immediately: no further tx_start is issued, and any tx_done arriving later is ignored.
- State IDLE:
  - On an edge with start=1: latch result→word and size→cnt; busy←1.
  - If HEADER_EN=1: tx_data←HEADER_BYTE, hdr←1. Otherwise: tx_data←result[7:0].
  - tx_start←1; go to WAIT.
  - Latency is therefore 1 cycle: start at edge k gives tx_start high in the cycle after edge k.
- State WAIT:
  - tx_start←0 after its single cycle.
  - Hold tx_data while waiting for tx_done.
  - On tx_done=1, if hdr=1: hdr←0; tx_data←word[7:0]; tx_start←1; stay in WAIT.
  - On tx_done=1, if hdr=0 and cnt≠0: word←word>>8; cnt←cnt−1; tx_data←(word>>8)[7:0]; tx_start←1; stay in WAIT.
  - On tx_done=1, if hdr=0 and cnt=0: busy←0; done←1; go to IDLE.
- Byte order is LSB first. Bytes sent are word[7:0], [15:8], [23:16], [31:24], truncated to size+1 bytes.
- Back-to-back: the next byte's tx_start is asserted in the cycle immediately after tx_done (zero idle cycles).
- done lasts exactly one cycle. start in that same done cycle is accepted, because the FSM is already in IDLE.
- Boundary rules:
  - start while busy=1: ignored; the frame in progress is unaffected.
  - result/size changes after acceptance: no effect (latched copies are used).
  - tx_done in IDLE: ignored.
  - tx_done in the same cycle as tx_start: impossible by construction, because WAIT samples tx_done only while tx_start=0. Any tx_done coinciding with tx_start is ignored.
  - size=0 with HEADER_EN=0: a single byte is sent; done follows its tx_done.
- Frame length is (size+1) bytes, plus 1 when HEADER_EN=1.
- tx_start count per frame always equals the frame length.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → tx_start=0, tx_data=00, busy=0, done=0; no tx_start within 20 idle cycles.
- HEADER_EN=1, result=32'h12345678, size=3, tx_done model returns a pulse 10 cycles after each tx_start → bytes A5,78,56,34,12 in order; 5 tx_start pulses; done pulses once, 1 cycle after the 5th tx_done; busy low in that cycle.
- HEADER_EN=0, result=32'h000000FF, size=0 → single byte FF; tx_start 1 cycle after start; done 1 cycle after tx_done.
- Busy protection: start with size=1, result=32'hAABBCCDD; pulse start again mid-frame with result=32'h11111111 → only DD,CC sent; the second start is ignored.
- Back-to-back: assert start in the done cycle with result=32'h0000BEEF, size=1 → new frame (A5),EF,BE starts with tx_start the next cycle.
- Reset mid-frame: assert reset=0 after the 2nd byte's tx_start → tx_start stays 0 and busy=0 from the next edge; a late tx_done produces no activity; a subsequent start sends a fresh full frame.
